// File: rtl/output_accum_pkg.sv
// Shared types and the saturating adder for the output accumulation buffer.
package output_accum_pkg;

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam int SAT_W = 64;

  // Operands arrive sign-extended to SAT_W; w is the real word width.
  // Returns {overflow, result}; result low w bits are the stored word.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int unsigned w,
                                             input logic saturate);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    logic o;
    s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
    min_v = -(65'sd1 <<< (w - 1));
    o     = (s > max_v) || (s < min_v);
    if (o && saturate) begin
      return {1'b1, (s > max_v) ? max_v[SAT_W-1:0] : min_v[SAT_W-1:0]};
    end
    return {o, s[SAT_W-1:0]};
  endfunction

endpackage

// File: rtl/output_sram_core.sv
// Raw DEPTH x DATA_W array, one sync read and one write port, read-first, no reset.
// Out-of-range writes are dropped and out-of-range reads return zero.
module output_sram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
    if ({1'b0, raddr} < DEPTH_L) begin
      rdata <= mem[raddr[IDX_W-1:0]];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/output_accum_sram.sv
// Accumulating output buffer: write / read-modify-write add with saturation, sticky overflow, clear sequencer.
// q is valid one cycle after each request; requests are ignored (q=0) while the clear sequencer is busy.
module output_accum_sram
  import output_accum_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  input  logic              wen,
  input  logic              acc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              ovf
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ovf_q;
  logic              s1_vld_q, s1_wen_q, s1_acc_q, s1_inr_q, fwd_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [DATA_W-1:0] s1_d_q, fwd_dat_q, q_hold_q;
  logic              clr_busy, s0_vld, s0_inr, s1_wr, s1_ovf;
  logic [DATA_W-1:0] rd_dat, old_dat, s1_res;
  logic [SAT_W:0]    sum;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_sum_hi;

  assign clr_busy = (state_q == CLEAR);
  assign s0_vld   = !clr_busy && !clr_start;
  assign s0_inr   = ({1'b0, addr} < DEPTH_L);
  assign s1_wr    = s1_vld_q && s1_wen_q && s1_inr_q;

  // Reset aborts the clear before the word under the counter is touched.
  assign mem_we    = clr_busy ? !rst : s1_wr;
  assign mem_waddr = clr_busy ? cnt_q : s1_addr_q;
  assign mem_wdata = clr_busy ? '0 : s1_res;

  output_sram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(addr),
    .rdata(rd_dat)
  );

  always_comb begin
    old_dat = fwd_q ? fwd_dat_q : rd_dat;
    sum     = sat_add({{(SAT_W-DATA_W){old_dat[DATA_W-1]}}, old_dat},
                      {{(SAT_W-DATA_W){s1_d_q[DATA_W-1]}}, s1_d_q},
                      DATA_W, SATURATE != 0);
    s1_res  = old_dat;
    s1_ovf  = 1'b0;
    if (s1_wen_q) begin
      if (s1_acc_q) begin
        s1_res = sum[DATA_W-1:0];
        s1_ovf = sum[SAT_W];
      end else begin
        s1_res = s1_d_q;
      end
    end
  end

  assign unused_sum_hi = ^sum[SAT_W-1:DATA_W];

  assign busy = clr_busy;
  assign q    = clr_busy ? '0 : (s1_vld_q ? s1_res : q_hold_q);
  assign ovf  = ovf_q | (s1_vld_q & s1_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      fwd_q    <= 1'b0;
      q_hold_q <= '0;
    end else begin
      s1_vld_q  <= s0_vld;
      s1_wen_q  <= wen;
      s1_acc_q  <= acc;
      s1_addr_q <= addr;
      s1_d_q    <= d;
      s1_inr_q  <= s0_inr;
      // The S1 write lands on this edge, too late for the array read just issued.
      fwd_q     <= s1_wr && (addr == s1_addr_q);
      fwd_dat_q <= s1_res;
      q_hold_q  <= q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else if (s1_vld_q && s1_ovf) begin
            ovf_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_A) state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
